apb_push_poller: RTL and testbench

APB requester that periodically sweeps the four push-button status registers (base, base+4, base+8, base+C) with read transfers. It extracts each register's status bit, keeps a debounced-by-sampling 4-bit push state, and emits one-cycle rising-edge events. It sits on the APB master side, opposite the push-button register bank, and feeds event pulses to downstream control logic.

---
 rtl/apb_push_poller.sv | 186 ++++++++++++++++++
 tb/tb_apb_push_poller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_push_poller.sv
// ---------------------------------------------------------------------------
// apb_push_poller
//
// APB read-only requester. It repeatedly sweeps the four push-button status
// registers at BASE_ADDR, BASE_ADDR+4, BASE_ADDR+8 and BASE_ADDR+C. From each
// register it extracts one status bit and keeps it as a 4-bit push state. It
// also emits a one-cycle rising-edge event for each bit.
//
// Ports
//   pclk, preset      clock (rising edge); asynchronous active-high reset
//   enable            level: 1 = run periodic sweeps
//   err_clr           one-cycle pulse that clears err
//   paddr/psel/penable/pwrite/pwdata   APB requester outputs
//                                      (pwrite and pwdata are tied 0)
//   prdata/pready/pslverr              APB completer responses
//   push_state[3:0]   last successfully sampled status bit per register
//   push_rise[3:0]    one-cycle pulse on a 0->1 change of push_state
//   err               sticky flag: timeout or pslverr seen
//   busy              1 while a transfer is in SETUP or ACCESS
// ---------------------------------------------------------------------------
module apb_push_poller #(
   parameter logic [31:0] BASE_ADDR     = 32'hA0010000,
   parameter int unsigned POLL_INTERVAL = 1000,
   parameter int unsigned TIMEOUT       = 16
) (
   input  logic        pclk,
   input  logic        preset,
   input  logic        enable,
   input  logic        err_clr,
   output logic [31:0] paddr,
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   output logic [31:0] pwdata,
   input  logic [31:0] prdata,
   input  logic        pready,
   input  logic        pslverr,
   output logic [3:0]  push_state,
   output logic [3:0]  push_rise,
   output logic        err,
   output logic        busy
);

   localparam int unsigned WW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_WAIT} state_t;

   state_t        r_state, w_next_state;
   logic [1:0]    r_idx, w_next_idx;
   logic [WW-1:0] r_wcnt, w_next_wcnt;
   logic [TW-1:0] r_tcnt, w_next_tcnt;

   logic [31:0]   r_paddr;
   logic          r_psel, r_penable, r_busy, r_err;
   logic [3:0]    r_push_state, r_push_rise;

   logic          w_xfer_done, w_timeout, w_end, w_ok, w_fault, w_bit;
   logic          w_unused_prdata;

   // Only bits 0, 7, 15 and 31 of prdata carry status.
   assign w_unused_prdata = ^{prdata[30:16], prdata[14:8], prdata[6:1]};

   // The ACCESS phase ends either when the completer answers or when pready
   // has been low for TIMEOUT consecutive ACCESS cycles.
   assign w_xfer_done = (r_state == S_ACCESS) && pready;
   assign w_timeout   = (r_state == S_ACCESS) && !pready && (r_tcnt == TW'(TIMEOUT - 1));
   assign w_end       = w_xfer_done || w_timeout;
   assign w_ok        = w_xfer_done && !pslverr;
   assign w_fault     = (w_xfer_done && pslverr) || w_timeout;

   // Each register places its status bit at a different position.
   always_comb begin
      w_bit = 1'b0;
      case (r_idx)
         2'd0: w_bit = prdata[0];
         2'd1: w_bit = prdata[7];
         2'd2: w_bit = prdata[15];
         2'd3: w_bit = prdata[31];
         default: w_bit = 1'b0;
      endcase
   end

   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned. Otherwise synthesis would infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_next_idx   = r_idx;
      w_next_wcnt  = r_wcnt;
      w_next_tcnt  = r_tcnt;
      case (r_state)
         S_IDLE: begin
            if (enable) begin
               w_next_idx   = 2'd0;
               w_next_state = S_SETUP;
            end
         end
         S_SETUP: begin
            w_next_tcnt  = '0;
            w_next_state = S_ACCESS;
         end
         S_ACCESS: begin
            // Dropping enable never aborts a transfer; it only decides what
            // follows once the transfer is over.
            if (w_end) begin
               if (!enable) begin
                  w_next_state = S_IDLE;
               end else if (r_idx != 2'd3) begin
                  w_next_idx   = r_idx + 2'd1;
                  w_next_state = S_SETUP;
               end else begin
                  w_next_wcnt  = WW'(POLL_INTERVAL - 1);
                  w_next_state = S_WAIT;
               end
            end else begin
               w_next_tcnt = r_tcnt + 1'b1;
            end
         end
         S_WAIT: begin
            if (!enable) begin
               w_next_state = S_IDLE;
            end else if (r_wcnt == '0) begin
               w_next_idx   = 2'd0;
               w_next_state = S_SETUP;
            end else begin
               w_next_wcnt = r_wcnt - 1'b1;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only. All registers
   // update together on the edge, whatever order these statements are in.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_state      <= S_IDLE;
         r_idx        <= 2'd0;
         r_wcnt       <= '0;
         r_tcnt       <= '0;
         r_paddr      <= '0;
         r_psel       <= 1'b0;
         r_penable    <= 1'b0;
         r_busy       <= 1'b0;
         r_err        <= 1'b0;
         r_push_state <= '0;
         r_push_rise  <= '0;
      end else begin
         r_state   <= w_next_state;
         r_idx     <= w_next_idx;
         r_wcnt    <= w_next_wcnt;
         r_tcnt    <= w_next_tcnt;
         // The bus controls are decoded from the next state. This way they
         // come straight from flops and line up with the state they describe.
         r_psel    <= (w_next_state == S_SETUP) || (w_next_state == S_ACCESS);
         r_penable <= (w_next_state == S_ACCESS);
         r_busy    <= (w_next_state == S_SETUP) || (w_next_state == S_ACCESS);
         if (w_next_state == S_SETUP)
            r_paddr <= BASE_ADDR + {28'd0, w_next_idx, 2'b00};

         r_push_rise <= '0;
         if (w_ok) begin
            r_push_state[r_idx] <= w_bit;
            if (w_bit && !r_push_state[r_idx])
               r_push_rise[r_idx] <= 1'b1;
         end

         // A new error takes priority over a clear in the same cycle.
         if (w_fault)
            r_err <= 1'b1;
         else if (err_clr)
            r_err <= 1'b0;
      end
   end

   assign paddr      = r_paddr;
   assign psel       = r_psel;
   assign penable    = r_penable;
   assign pwrite     = 1'b0;
   assign pwdata     = '0;
   assign push_state = r_push_state;
   assign push_rise  = r_push_rise;
   assign err        = r_err;
   assign busy       = r_busy;

endmodule

// File: tb/tb_apb_push_poller.sv
// ---------------------------------------------------------------------------
// tb_apb_push_poller
//
// Directed bench for apb_push_poller with its default parameters
// (BASE_ADDR = A0010000, POLL_INTERVAL = 1000, TIMEOUT = 16).
//
// A small behavioural completer answers each register. Per register it can
// insert wait states, never answer, flag pslverr, or return chosen data.
// Outputs are sampled on the falling edge of the clock.
// ---------------------------------------------------------------------------
module tb_apb_push_poller;

   localparam logic [31:0] BASE = 32'hA0010000;

   logic        pclk;
   logic        preset;
   logic        enable;
   logic        err_clr;
   logic [31:0] paddr;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;
   logic [3:0]  push_state;
   logic [3:0]  push_rise;
   logic        err;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural completer configuration, one entry per register.
   logic [31:0] cfg_rdata   [4];
   int          cfg_wait    [4];
   logic        cfg_noready [4];
   logic        cfg_slverr  [4];
   int          acc_cnt = 0;
   logic [1:0]  s_idx;

   apb_push_poller dut (
      .pclk       (pclk),
      .preset     (preset),
      .enable     (enable),
      .err_clr    (err_clr),
      .paddr      (paddr),
      .psel       (psel),
      .penable    (penable),
      .pwrite     (pwrite),
      .pwdata     (pwdata),
      .prdata     (prdata),
      .pready     (pready),
      .pslverr    (pslverr),
      .push_state (push_state),
      .push_rise  (push_rise),
      .err        (err),
      .busy       (busy)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Count the ACCESS cycles already spent waiting, for wait-state insertion.
   always @(posedge pclk) begin
      if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
      else                            acc_cnt <= 0;
   end

   always_comb begin
      s_idx   = paddr[3:2];
      pready  = psel && penable && !cfg_noready[s_idx] && (acc_cnt >= cfg_wait[s_idx]);
      prdata  = cfg_rdata[s_idx];
      pslverr = pready && cfg_slverr[s_idx];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge pclk);
   endtask

   task automatic set_all(input logic [31:0] data);
      for (int i = 0; i < 4; i++) begin
         cfg_rdata[i]   = data;
         cfg_wait[i]    = 0;
         cfg_noready[i] = 1'b0;
         cfg_slverr[i]  = 1'b0;
      end
   endtask

   task automatic do_reset();
      preset  = 1'b1;
      enable  = 1'b0;
      err_clr = 1'b0;
      set_all(32'h0);
      tick(2);
      preset = 1'b0;
      tick(1);
   endtask

   // Step to the first falling edge with psel high, within a cycle budget.
   task automatic wait_psel(input string tag);
      int n = 0;
      while (psel !== 1'b1 && n < 100) begin
         tick(1);
         n++;
      end
      if (psel !== 1'b1) check({tag, "_psel_timeout"}, 32'(psel), 32'd1);
   endtask

   // Count ACCESS cycles, checking that paddr is held throughout.
   task automatic count_access(input string tag, input logic [31:0] addr, output int n);
      n = 0;
      while (penable === 1'b1 && n < 40) begin
         check({tag, "_paddr_held"}, paddr, addr);
         n++;
         tick(1);
      end
   endtask

   initial begin
      int          n;
      logic [3:0]  rises;
      logic        saw_psel;

      preset  = 1'b1;
      enable  = 1'b0;
      err_clr = 1'b0;
      set_all(32'h0);

      // ---- Reset values -------------------------------------------------
      do_reset();
      check("rst_psel",       32'(psel),       32'd0);
      check("rst_penable",    32'(penable),    32'd0);
      check("rst_paddr",      paddr,           32'd0);
      check("rst_pwrite",     32'(pwrite),     32'd0);
      check("rst_pwdata",     pwdata,          32'd0);
      check("rst_push_state", 32'(push_state), 32'd0);
      check("rst_push_rise",  32'(push_rise),  32'd0);
      check("rst_err",        32'(err),        32'd0);
      check("rst_busy",       32'(busy),       32'd0);

      // ---- Zero-wait sweep, all status bits set -------------------------
      set_all(32'h80008081);
      enable = 1'b1;
      tick(1);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("sw_setup_paddr%0d", k), paddr, BASE + 32'(4 * k));
         check($sformatf("sw_setup_psel%0d", k), 32'(psel), 32'd1);
         check($sformatf("sw_setup_pen%0d", k), 32'(penable), 32'd0);
         check($sformatf("sw_setup_busy%0d", k), 32'(busy), 32'd1);
         tick(1);
         check($sformatf("sw_access_pen%0d", k), 32'(penable), 32'd1);
         check($sformatf("sw_access_paddr%0d", k), paddr, BASE + 32'(4 * k));
         tick(1);
         check($sformatf("sw_state%0d", k), 32'(push_state), 32'((1 << (k + 1)) - 1));
         check($sformatf("sw_rise%0d", k), 32'(push_rise), 32'(1 << k));
      end
      check("sw_wait_psel", 32'(psel), 32'd0);
      check("sw_wait_busy", 32'(busy), 32'd0);
      check("sw_wait_paddr", paddr, BASE + 32'hC);
      n = 0;
      rises = 4'd0;
      while (psel !== 1'b1 && n < 1100) begin
         tick(1);
         n++;
         rises |= push_rise;
      end
      check("sw_interval", 32'(n), 32'd1000);
      check("sw2_paddr", paddr, BASE);
      repeat (8) begin
         tick(1);
         rises |= push_rise;
      end
      check("sw2_no_rise", 32'(rises), 32'd0);
      check("sw2_state", 32'(push_state), 32'hF);
      check("sw_err", 32'(err), 32'd0);

      // ---- Three wait states on register 1 ------------------------------
      do_reset();
      cfg_rdata[1] = 32'h00000080;
      cfg_wait[1]  = 3;
      enable = 1'b1;
      wait_psel("ws");
      tick(2);
      check("ws_setup_paddr", paddr, BASE + 32'h4);
      tick(1);
      count_access("ws", BASE + 32'h4, n);
      check("ws_access_len", 32'(n), 32'd4);
      check("ws_rise", 32'(push_rise), 32'b0010);
      check("ws_state", 32'(push_state), 32'b0010);
      check("ws_err", 32'(err), 32'd0);

      // ---- Timeout on register 2, then err_clr --------------------------
      do_reset();
      set_all(32'hFFFFFFFF);
      cfg_noready[2] = 1'b1;
      enable = 1'b1;
      wait_psel("to");
      tick(4);
      check("to_setup_paddr", paddr, BASE + 32'h8);
      check("to_err_before", 32'(err), 32'd0);
      tick(1);
      count_access("to", BASE + 32'h8, n);
      check("to_access_len", 32'(n), 32'd16);
      check("to_err", 32'(err), 32'd1);
      check("to_state", 32'(push_state), 32'b0011);
      check("to_next_paddr", paddr, BASE + 32'hC);
      check("to_next_setup", 32'(penable), 32'd0);
      tick(2);
      check("to_state_after", 32'(push_state), 32'b1011);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check("to_err_clr", 32'(err), 32'd0);

      // ---- pslverr on register 0 ----------------------------------------
      do_reset();
      set_all(32'hFFFFFFFF);
      cfg_slverr[0] = 1'b1;
      enable = 1'b1;
      wait_psel("se");
      tick(2);
      check("se_state", 32'(push_state), 32'd0);
      check("se_rise", 32'(push_rise), 32'd0);
      check("se_err", 32'(err), 32'd1);

      // ---- Drop enable during ACCESS on register 1 ----------------------
      do_reset();
      cfg_rdata[1] = 32'h00000080;
      cfg_wait[1]  = 2;
      enable = 1'b1;
      wait_psel("de");
      tick(3);
      enable = 1'b0;
      count_access("de", BASE + 32'h4, n);
      check("de_access_len", 32'(n), 32'd3);
      check("de_rise", 32'(push_rise), 32'b0010);
      check("de_psel", 32'(psel), 32'd0);
      check("de_busy", 32'(busy), 32'd0);
      saw_psel = 1'b0;
      repeat (20) begin
         tick(1);
         saw_psel |= psel;
      end
      check("de_no_more_access", 32'(saw_psel), 32'd0);
      check("de_paddr_kept", paddr, BASE + 32'h4);

      // ---- Asynchronous reset mid-ACCESS --------------------------------
      do_reset();
      set_all(32'h80008081);
      cfg_wait[1] = 5;
      enable = 1'b1;
      wait_psel("ar");
      tick(3);
      check("ar_in_access", 32'(penable), 32'd1);
      check("ar_state_before", 32'(push_state), 32'b0001);
      #2 preset = 1'b1;
      #1;
      check("ar_psel", 32'(psel), 32'd0);
      check("ar_penable", 32'(penable), 32'd0);
      check("ar_push_state", 32'(push_state), 32'd0);
      tick(1);
      preset = 1'b0;
      wait_psel("ar2");
      check("ar_restart_paddr", paddr, BASE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
